// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: operation codes, RV32 major opcodes,
// skid-buffer state and the arithmetic funct3 mapping used by R and I types.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_JAL = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_NE  = 4'b1001,
    ALU_LT  = 4'b1010,
    ALU_GE  = 4'b1011,
    ALU_SLT = 4'b1100,
    ALU_SUB = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_t;

  function automatic logic arith_f3_legal(input logic [2:0] f3);
    return f3 != 3'b011;
  endfunction

  // SUB only exists in the register form; ADDI ignores Funct7.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic f7b5,
                                       input logic is_reg);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b001:  op = ALU_SLL;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b010:  op = ALU_SLT;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of opcode/funct fields into ALU operands and
// operation code; unsupported encodings yield zeros with illegal set.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] src_a,
  output logic [DATA_WIDTH-1:0] src_b,
  output alu_op_t               op,
  output logic                  illegal
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    op      = ALU_AND;
    src_a   = '0;
    src_b   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        src_a   = rd1;
        src_b   = rd2;
        op      = arith_op(funct3, funct7[5], 1'b1);
        illegal = !arith_f3_legal(funct3);
      end
      OP_I: begin
        src_a   = rd1;
        src_b   = imm;
        op      = arith_op(funct3, funct7[5], 1'b0);
        illegal = !arith_f3_legal(funct3);
      end
      OP_LOAD, OP_STORE: begin
        src_a = rd1;
        src_b = imm;
        op    = ALU_ADD;
      end
      OP_BRANCH: begin
        src_a = rd1;
        src_b = rd2;
        case (funct3)
          3'b000:  op = ALU_EQ;
          3'b001:  op = ALU_NE;
          3'b100:  op = ALU_LT;
          3'b101:  op = ALU_GE;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: begin
        src_a = rd1;
        src_b = imm;
        op    = ALU_JAL;
      end
      OP_LUI: begin
        src_b = imm;
        op    = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal entries still flow downstream, but carry no operand data.
    if (illegal) begin
      op    = ALU_AND;
      src_a = '0;
      src_b = '0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry skid buffer between ID and the EX-stage ALU; registers the decoded
// operation so EX can stall without dropping instructions.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               Opcode,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     Illegal
);

  buf_state_t state_q, state_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  alu_op_t               dec_op;
  logic                  dec_ill;

  logic [DATA_WIDTH-1:0] src_a_q [2];
  logic [DATA_WIDTH-1:0] src_b_q [2];
  logic [ALU_OP_W-1:0]   op_q    [2];
  logic                  ill_q   [2];

  alu_op_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .opcode  (Opcode),
    .funct3  (Funct3),
    .funct7  (Funct7),
    .rd1     (RD1),
    .rd2     (RD2),
    .imm     (Imm),
    .src_a   (dec_a),
    .src_b   (dec_b),
    .op      (dec_op),
    .illegal (dec_ill)
  );

  // Flush beats a same-cycle push; a same-cycle pop has already been taken by EX.
  assign push = in_valid && in_ready_q && !flush;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BUF_EMPTY;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    if (flush) begin
      state_d  = BUF_EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: if (push) state_d = BUF_ONE;
        BUF_ONE: begin
          if (push && !pop)      state_d = BUF_FULL;
          else if (pop && !push) state_d = BUF_EMPTY;
        end
        BUF_FULL:  if (pop) state_d = BUF_ONE;
        default:   state_d = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid  = (state_q != BUF_EMPTY);
    in_ready_d = (state_d != BUF_FULL);
  end

  assign in_ready = in_ready_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          src_a_q[gi] <= '0;
          src_b_q[gi] <= '0;
          op_q[gi]    <= '0;
          ill_q[gi]   <= 1'b0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          src_a_q[gi] <= dec_a;
          src_b_q[gi] <= dec_b;
          op_q[gi]    <= dec_op;
          ill_q[gi]   <= dec_ill;
        end
      end
    end
  endgenerate

  assign SrcA      = src_a_q[rd_ptr_q];
  assign SrcB      = src_b_q[rd_ptr_q];
  assign Operation = OPCODE_LENGTH'(op_q[rd_ptr_q]);
  assign Illegal   = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus hand-written
// stall, flush and asynchronous-reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] RD1, RD2, Imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic        Illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Opcode    (Opcode),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .RD1       (RD1),
    .RD2       (RD2),
    .Imm       (Imm),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .Illegal   (Illegal)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm);
    Opcode   = opc;
    Funct3   = f3;
    Funct7   = f7;
    RD1      = rd1;
    RD2      = rd2;
    Imm      = imm;
    in_valid = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".op"}, 32'(Operation), 32'(op));
    check({tag, ".srca"}, SrcA, a);
    check({tag, ".srcb"}, SrcB, b);
  endtask

  initial begin
    //            opc       f3      f7        rd1            rd2        imm            op       a              b              ill
    vecs[0]  = '{7'h33, 3'b000, 7'h00, 32'd5,         32'd7,     32'd0,         4'b0010, 32'd5,         32'd7,         1'b0};
    vecs[1]  = '{7'h33, 3'b000, 7'h20, 32'd5,         32'd7,     32'd0,         4'b1101, 32'd5,         32'd7,         1'b0};
    vecs[2]  = '{7'h13, 3'b101, 7'h20, 32'h80000000,  32'd0,     32'd3,         4'b0111, 32'h80000000,  32'd3,         1'b0};
    vecs[3]  = '{7'h37, 3'b000, 7'h00, 32'hdead,      32'hbeef,  32'h12345000,  4'b0010, 32'd0,         32'h12345000,  1'b0};
    vecs[4]  = '{7'h63, 3'b101, 7'h00, 32'd9,         32'd4,     32'h10,        4'b1011, 32'd9,         32'd4,         1'b0};
    vecs[5]  = '{7'h73, 3'b000, 7'h00, 32'd1,         32'd2,     32'd3,         4'b0000, 32'd0,         32'd0,         1'b1};
    vecs[6]  = '{7'h13, 3'b000, 7'h20, 32'd10,        32'd0,     32'hffffffff,  4'b0010, 32'd10,        32'hffffffff,  1'b0};
    vecs[7]  = '{7'h03, 3'b010, 7'h00, 32'd100,       32'h55,    32'd8,         4'b0010, 32'd100,       32'd8,         1'b0};
    vecs[8]  = '{7'h23, 3'b010, 7'h00, 32'd200,       32'h66,    32'hfffffffc,  4'b0010, 32'd200,       32'hfffffffc,  1'b0};
    vecs[9]  = '{7'h67, 3'b000, 7'h00, 32'd300,       32'd1,     32'd4,         4'b0011, 32'd300,       32'd4,         1'b0};
    vecs[10] = '{7'h6f, 3'b000, 7'h00, 32'd400,       32'd1,     32'h800,       4'b0011, 32'd400,       32'h800,       1'b0};
    vecs[11] = '{7'h63, 3'b010, 7'h00, 32'd1,         32'd2,     32'd3,         4'b0000, 32'd0,         32'd0,         1'b1};
    vecs[12] = '{7'h33, 3'b010, 7'h00, 32'ha,         32'hb,     32'd0,         4'b1100, 32'ha,         32'hb,         1'b0};
    vecs[13] = '{7'h33, 3'b101, 7'h00, 32'hf0,        32'd4,     32'd0,         4'b0101, 32'hf0,        32'd4,         1'b0};
    vecs[14] = '{7'h13, 3'b100, 7'h00, 32'hf,         32'd0,     32'hff0,       4'b0110, 32'hf,         32'hff0,       1'b0};
    vecs[15] = '{7'h63, 3'b001, 7'h00, 32'd3,         32'd3,     32'd0,         4'b1001, 32'd3,         32'd3,         1'b0};
    vecs[16] = '{7'h63, 3'b100, 7'h00, 32'd1,         32'd2,     32'd0,         4'b1010, 32'd1,         32'd2,         1'b0};
    vecs[17] = '{7'h63, 3'b000, 7'h00, 32'd7,         32'd7,     32'd0,         4'b1000, 32'd7,         32'd7,         1'b0};
    vecs[18] = '{7'h33, 3'b011, 7'h00, 32'd1,         32'd2,     32'd0,         4'b0000, 32'd0,         32'd0,         1'b1};
    vecs[19] = '{7'h13, 3'b001, 7'h00, 32'd6,         32'd0,     32'd2,         4'b0100, 32'd6,         32'd2,         1'b0};
    vecs[20] = '{7'h33, 3'b111, 7'h00, 32'hc,         32'ha,     32'd0,         4'b0000, 32'hc,         32'ha,         1'b0};
    vecs[21] = '{7'h13, 3'b110, 7'h00, 32'd1,         32'd0,     32'd2,         4'b0001, 32'd1,         32'd2,         1'b0};
    vecs[22] = '{7'h13, 3'b101, 7'h00, 32'h80,        32'd0,     32'd1,         4'b0101, 32'h80,        32'd1,         1'b0};
    vecs[23] = '{7'h33, 3'b001, 7'h00, 32'd1,         32'd5,     32'd0,         4'b0100, 32'd1,         32'd5,         1'b0};
    vecs[24] = '{7'h00, 3'b000, 7'h00, 32'd1,         32'd2,     32'd3,         4'b0000, 32'd0,         32'd0,         1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    Opcode    = '0;
    Funct3    = '0;
    Funct7    = '0;
    RD1       = '0;
    RD2       = '0;
    Imm       = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.op", 32'(Operation), 32'd0);
    check("rst.srca", SrcA, 32'd0);
    check("rst.srcb", SrcB, 32'd0);
    check("rst.illegal", 32'(Illegal), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check("rel.out_valid", 32'(out_valid), 32'd0);

    // Decode table, one instruction at a time with EX always ready
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rd1, vecs[i].rd2, vecs[i].imm);
      @(negedge clk);
      in_valid = 1'b0;
      check_head($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d.illegal", i), 32'(Illegal), 32'(vecs[i].ill));
      $display("vec %0d opc=%02h f3=%0d op=%0h a=%0h b=%0h ill=%0d", i, vecs[i].opc, vecs[i].f3,
               Operation, SrcA, SrcB, Illegal);
      @(negedge clk);
      check($sformatf("v%0d.drained", i), 32'(out_valid), 32'd0);
    end

    // Stall: three back-to-back pushes against a blocked EX stage
    out_ready = 1'b0;
    drive(7'h33, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0);
    @(negedge clk);
    check("stall.in_ready1", 32'(in_ready), 32'd1);
    check_head("stall.e1a", 4'b0010, 32'd1, 32'd2);
    drive(7'h33, 3'b110, 7'h00, 32'd3, 32'd4, 32'd0);
    @(negedge clk);
    check("stall.in_ready2", 32'(in_ready), 32'd0);
    check_head("stall.e1b", 4'b0010, 32'd1, 32'd2);
    drive(7'h33, 3'b100, 7'h00, 32'd5, 32'd6, 32'd0);
    @(negedge clk);
    check("stall.in_ready3", 32'(in_ready), 32'd0);
    check_head("stall.e1c", 4'b0010, 32'd1, 32'd2);
    $display("stall held head op=%0h a=%0h in_ready=%0d", Operation, SrcA, in_ready);
    out_ready = 1'b1;
    @(negedge clk);
    check_head("stall.e2", 4'b0001, 32'd3, 32'd4);
    check("stall.in_ready4", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("stall.e3", 4'b0110, 32'd5, 32'd6);
    $display("stall drain third op=%0h a=%0h", Operation, SrcA);
    @(negedge clk);
    check("stall.empty", 32'(out_valid), 32'd0);

    // Flush on a full buffer with a competing push
    out_ready = 1'b0;
    drive(7'h33, 3'b000, 7'h00, 32'd11, 32'd12, 32'd0);
    @(negedge clk);
    drive(7'h33, 3'b000, 7'h00, 32'd13, 32'd14, 32'd0);
    @(negedge clk);
    check("flush.full", 32'(in_ready), 32'd0);
    drive(7'h33, 3'b000, 7'h20, 32'd77, 32'd88, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    $display("flush out_valid=%0d in_ready=%0d", out_valid, in_ready);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("flush.gone%0d", k), 32'(out_valid), 32'd0);
    end
    drive(7'h33, 3'b000, 7'h00, 32'd21, 32'd22, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("flush.after", 4'b0010, 32'd21, 32'd22);
    @(negedge clk);

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(7'h33, 3'b000, 7'h20, 32'd31, 32'd32, 32'd0);
    @(negedge clk);
    drive(7'h33, 3'b111, 7'h00, 32'd33, 32'd34, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("areset.full", 32'(in_ready), 32'd0);
    check_head("areset.pre", 4'b1101, 32'd31, 32'd32);
    #2 reset = 1'b0;
    #1;
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check("areset.op", 32'(Operation), 32'd0);
    check("areset.srca", SrcA, 32'd0);
    check("areset.in_ready", 32'(in_ready), 32'd0);
    $display("async reset out_valid=%0d op=%0h", out_valid, Operation);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("areset.rel_valid", 32'(out_valid), 32'd0);
    check("areset.rel_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Producer side of the ALU operand/operation interface. Accepts decoded-instruction fields from the ID stage over a valid/ready handshake and translates opcode/funct3/funct7 into the 4-bit ALU operation code. Selects SrcA/SrcB and holds the result in a 2-entry skid buffer that feeds the EX-stage ALU. Registering the operation here breaks the decode-to-ALU combinational path and lets the EX stage stall without losing instructions.

## Interface

Parameters:
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, ALU operation code width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- Opcode  in  7  instr[6:0]
- Funct3  in  3  instr[14:12]
- Funct7  in  7  instr[31:25]
- RD1  in  DATA_WIDTH  rs1 value
- RD2  in  DATA_WIDTH  rs2 value
- Imm  in  DATA_WIDTH  sign-extended immediate
- flush  in  1  discard all buffered entries (branch taken)
- out_valid  out  1  SrcA/SrcB/Operation valid
- out_ready  in  1  EX stage consumes this cycle
- SrcA  out  DATA_WIDTH  ALU operand A
- SrcB  out  DATA_WIDTH  ALU operand B
- Operation  out  OPCODE_LENGTH  ALU operation code
- Illegal  out  1  head entry carried an unsupported encoding

## Operation

- Codes: AND 0000, OR 0001, ADD 0010, JAL 0011, SLL 0100, SRL 0101, XOR 0110, SRA 0111, EQ 1000, NE 1001, LT 1010, GE 1011, SLT 1100, SUB 1101.
- R-type 0110011, SrcA=RD1, SrcB=RD2: f3 000 → ADD (Funct7[5]=0) or SUB (=1); 111 AND; 110 OR; 100 XOR; 001 SLL; 101 → SRL (Funct7[5]=0) or SRA (=1); 010 SLT.
- I-ALU 0010011, SrcB=Imm: same f3 map, except f3 000 is always ADD; f3 101 uses Funct7[5] to pick SRL/SRA.
- Load 0000011 and Store 0100011: ADD, SrcA=RD1, SrcB=Imm.
- Branch 1100011, SrcA=RD1, SrcB=RD2: f3 000 EQ, 001 NE, 100 LT, 101 GE.
- JAL 1101111 and JALR 1100111: JAL code, SrcA=RD1, SrcB=Imm.
- LUI 0110111: ADD, SrcA=0, SrcB=Imm.
- Anything else, including unlisted f3 values: Operation=0000, SrcA=SrcB=0, Illegal=1. The entry still flows; it is not dropped.
- Buffer states: EMPTY, ONE, FULL, indexed by a 1-bit read pointer and a 1-bit write pointer that wrap at 2.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop in ONE keeps the state at ONE.
  - Push in FULL cannot occur.
  - Pop in EMPTY is ignored.
- flush: next state EMPTY and both pointers cleared. A push in the same cycle is dropped, because flush wins. A pop in the same cycle is counted by EX, and the head has already been consumed.

## Timing

- Reset values: in_ready=1 after release (0 while reset asserted), out_valid=0, SrcA=SrcB=0, Operation=0000, Illegal=0, state EMPTY.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready is registered, and equals 1 unless the state is FULL.
- Outputs are driven from the head entry register. They are stable while out_valid=1 && out_ready=0.
- Reset asserted mid-operation clears all entries immediately, asynchronously.

## Structure

- Shared package alu_pkg holds:
  - alu_op_t, an enum of the 14 codes above, width OPCODE_LENGTH
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI
  - the buffer state enum
- Sub-module alu_op_decode: purely combinational mapping of Opcode/Funct3/Funct7/RD1/RD2/Imm to {SrcA, SrcB, Operation, Illegal}. The top module is the skid buffer around it.

## Test plan

- Reset, then R-type ADD (Funct7=0000000) with RD1=5, RD2=7, out_ready=1 → next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=7. Same instruction with Funct7=0100000 → Operation=1101.
- I-type SRAI (f3=101, Funct7[5]=1) with Imm=3 → Operation=0111, SrcB=3. LUI with Imm=0x12345000 → SrcA=0, Operation=0010.
- Branch BGE (f3=101) → Operation=1011, SrcB=RD2. Opcode 1110011 → Illegal=1, Operation=0000.
- Hold out_ready=0 and push 3 instructions back-to-back → in_ready falls after the 2nd push, the 3rd is held at the input, and the outputs stay at the 1st entry. Release out_ready → entries emerge in order 1, 2, 3.
- FULL buffer, then assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- Assert reset while in FULL → out_valid=0 and Operation=0000 immediately, with no clock edge required.
